// File: rtl/deser_queue_if.sv
// Bus bundle for deser_queue: serial bit input, pop request and queue status/outputs.
interface deser_queue_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
);
  logic                    data_in;
  logic                    write_in;
  logic                    status_out;
  logic                    dequeue_in;
  logic [DATA_WIDTH-1:0]   data_out;
  logic [$clog2(DEPTH):0]  len_out;
  logic                    underflow_out;
  logic                    parity_err_out;

  modport master (
    output data_in, write_in, dequeue_in,
    input  status_out, data_out, len_out, underflow_out, parity_err_out
  );

  modport slave (
    input  data_in, write_in, dequeue_in,
    output status_out, data_out, len_out, underflow_out, parity_err_out
  );
endinterface

// File: rtl/deser_queue.sv
// Serial-to-parallel deserializer feeding a word FIFO with edge-detected strobes.
// Optional even-parity bit per word enabled by macro DESER_QUEUE_PARITY_EN.
module deser_queue #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned LSB_FIRST  = 1
) (
  input logic         clock,
  input logic         reset,
  deser_queue_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
`ifdef DESER_QUEUE_PARITY_EN
  localparam int unsigned LastBit = DATA_WIDTH;
`else
  localparam int unsigned LastBit = DATA_WIDTH - 1;
`endif

  logic                  write_prev_q, deq_prev_q;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         len_q, len_d;
  logic                  status_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  underflow_q, parity_err_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  write_edge, deq_edge, accept, last_bit, push, pop, par_fail;
  logic [CW-1:0]         bit_pos;
  logic [DATA_WIDTH-1:0] word;

  always_comb begin
    write_edge = bus.write_in & ~write_prev_q;
    deq_edge   = bus.dequeue_in & ~deq_prev_q;
    accept     = write_edge & status_q;
    last_bit   = (bit_cnt_q == CW'(LastBit));
    bit_pos    = (LSB_FIRST != 0) ? bit_cnt_q : (CW'(DATA_WIDTH - 1) - bit_cnt_q);

    // Word as it stands including the bit accepted this cycle.
    word = sreg_q;
    if (accept && (bit_cnt_q < CW'(DATA_WIDTH))) begin
      for (int i = 0; i < int'(DATA_WIDTH); i++) begin
        if (bit_pos == CW'(i)) word[i] = bus.data_in;
      end
    end

`ifdef DESER_QUEUE_PARITY_EN
    par_fail = ^{sreg_q, bus.data_in};
`else
    par_fail = 1'b0;
`endif

    push = accept & last_bit & ~par_fail;
    pop  = deq_edge & (len_q != '0);

    unique case ({push, pop})
      2'b10:   len_d = len_q + LW'(1);
      2'b01:   len_d = len_q - LW'(1);
      default: len_d = len_q;
    endcase

    bit_cnt_d = bit_cnt_q;
    sreg_d    = sreg_q;
    if (accept) begin
      if (last_bit) begin
        bit_cnt_d = '0;
        sreg_d    = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
        sreg_d    = word;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_prev_q <= 1'b1;
      deq_prev_q   <= 1'b1;
      bit_cnt_q    <= '0;
      sreg_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      status_q     <= 1'b0;
      data_q       <= '0;
      underflow_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      write_prev_q <= bus.write_in;
      deq_prev_q   <= bus.dequeue_in;
      bit_cnt_q    <= bit_cnt_d;
      sreg_q       <= sreg_d;
      len_q        <= len_d;
      status_q     <= (len_d != LW'(DEPTH));
      underflow_q  <= deq_edge & (len_q == '0);
      parity_err_q <= accept & last_bit & par_fail;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        data_q   <= mem[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= word;
  end

  assign bus.status_out     = status_q;
  assign bus.data_out       = data_q;
  assign bus.len_out        = len_q;
  assign bus.underflow_out  = underflow_q;
  assign bus.parity_err_out = parity_err_q;
endmodule

// File: tb/tb_deser_queue.sv
// Scoreboard bench for deser_queue: words queued by the bench model, checked on each pop.
module tb_deser_queue;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [DW-1:0] sb [$];

  deser_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  deser_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LSB_FIRST(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic sb_pop(output logic [DW-1:0] exp);
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      exp = '0;
    end else begin
      exp = sb.pop_front();
    end
  endtask

  // Sends one word LSB first; optional parity bit and optional pop on the final strobe.
  task automatic send_word(input logic [DW-1:0] w, input bit pop_last, input bit bad_par);
    logic [DW:0]   bits;
    int            total;
    logic [DW-1:0] exp;
    bits  = {^w ^ bad_par, w};
    total = int'(DW);
`ifdef DESER_QUEUE_PARITY_EN
    total = int'(DW) + 1;
`endif
    for (int i = 0; i < total; i++) begin
      @(negedge clock);
      bus.data_in  = bits[i];
      bus.write_in = 1'b1;
      if (i == total - 1 && pop_last) bus.dequeue_in = 1'b1;
      @(negedge clock);
      bus.write_in   = 1'b0;
      bus.dequeue_in = 1'b0;
    end
    if (pop_last) begin
      sb_pop(exp);
      check("conc_data", 32'(bus.data_out), 32'(exp));
    end
    if (sb.size() < DEPTH && !bad_par) sb.push_back(w);
    check("len_after_send", 32'(bus.len_out), sb.size());
  endtask

  task automatic pop_word();
    logic [DW-1:0] exp;
    @(negedge clock);
    bus.dequeue_in = 1'b1;
    @(negedge clock);
    bus.dequeue_in = 1'b0;
    sb_pop(exp);
    check("pop_data", 32'(bus.data_out), 32'(exp));
    check("len_after_pop", 32'(bus.len_out), sb.size());
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    bus.data_in    = 1'b0;
    bus.write_in   = 1'b0;
    bus.dequeue_in = 1'b0;
    #23;
    check("rst_len", 32'(bus.len_out), 0);
    check("rst_data", 32'(bus.data_out), 0);
    check("rst_status", 32'(bus.status_out), 0);
    check("rst_underflow", 32'(bus.underflow_out), 0);
    check("rst_parity", 32'(bus.parity_err_out), 0);
    @(negedge clock);
    reset = 1'b0;
    #1 check("status_before_edge", 32'(bus.status_out), 0);
    @(negedge clock);
    check("status_after_edge", 32'(bus.status_out), 1);

    // Single word round trip.
    send_word(8'h99, 1'b0, 1'b0);
    pop_word();

    // Underflow pulse, data_out held.
    @(negedge clock);
    bus.dequeue_in = 1'b1;
    @(negedge clock);
    bus.dequeue_in = 1'b0;
    check("underflow_hi", 32'(bus.underflow_out), 1);
    check("underflow_data", 32'(bus.data_out), 32'h99);
    check("underflow_len", 32'(bus.len_out), 0);
    @(negedge clock);
    check("underflow_lo", 32'(bus.underflow_out), 0);

    // Fill, overflow attempt, drain.
    for (int i = 1; i <= 8; i++) send_word(DW'(i), 1'b0, 1'b0);
    check("full_status", 32'(bus.status_out), 0);
    send_word(8'hFF, 1'b0, 1'b0);
    check("full_len", 32'(bus.len_out), 8);
    for (int i = 0; i < 8; i++) begin
      pop_word();
      if (i == 0) check("status_reopen", 32'(bus.status_out), 1);
    end

    // Concurrent push and pop at len 3 and at len 1.
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    send_word(8'h33, 1'b0, 1'b0);
    send_word(8'h44, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pop_word();
    send_word(8'h55, 1'b0, 1'b0);
    send_word(8'h66, 1'b1, 1'b0);
    pop_word();

    // Mid-word reset with write_in held high across release.
    send_word(8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      bus.data_in  = 1'b1;
      bus.write_in = 1'b1;
      @(negedge clock);
      bus.write_in = 1'b0;
    end
    @(negedge clock);
    bus.write_in = 1'b1;
    #2 reset = 1'b1;
    #1 check("midrst_len", 32'(bus.len_out), 0);
    check("midrst_status", 32'(bus.status_out), 0);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    bus.write_in = 1'b0;
    send_word(8'hA5, 1'b0, 1'b0);
    pop_word();

`ifdef DESER_QUEUE_PARITY_EN
    send_word(8'h99, 1'b0, 1'b0);
    send_word(8'h99, 1'b0, 1'b1);
    check("par_err_hi", 32'(bus.parity_err_out), 1);
    @(negedge clock);
    check("par_err_lo", 32'(bus.parity_err_out), 0);
    pop_word();
`else
    check("par_err_tied", 32'(bus.parity_err_out), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/deser_queue.md
DESER_QUEUE -- requirements
Module: deser_queue

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: serial word width in bits, legal range 2..32.
REQ-002 The block SHALL have parameter DEPTH, default 8: queue depth in words, a power of two in the range 2..64.
REQ-003 The block SHALL have parameter LSB_FIRST, default 1: 1 means the first received bit is word bit 0; 0 means the first received bit is bit DATA_WIDTH-1.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 data_in  in  1  serial data bit, sampled on a write_in rising edge.
REQ-007 write_in  in  1  bit strobe; each 0->1 transition is one bit.
REQ-008 status_out  out  1  high when the block can accept serial bits (queue not full).
REQ-009 dequeue_in  in  1  pop request; each 0->1 transition is one pop.
REQ-010 data_out  out  DATA_WIDTH  last popped word.
REQ-011 len_out  out  $clog2(DEPTH)+1  number of words currently queued.
REQ-012 underflow_out  out  1  one-cycle pulse when a pop is requested while the queue is empty.
REQ-013 parity_err_out  out  1  one-cycle pulse when a received word is rejected on parity.

Function
REQ-014 Both strobes SHALL be edge-detected using registered previous values; an edge is "strobe=1 and previous=0" in a cycle.
REQ-015 A write edge SHALL be accepted only when status_out=1; write edges while status_out=0 SHALL be ignored and SHALL NOT advance the bit counter.
REQ-016 Accepted bits SHALL be placed in a shift register at the position set by LSB_FIRST, and a bit counter SHALL advance from 0 to DATA_WIDTH-1.
REQ-017 On the clock edge that accepts the final bit, the assembled word (including that bit) SHALL be written to the queue tail, len_out SHALL increment on that same edge, and the bit counter SHALL return to 0.
REQ-018 status_out SHALL be registered and SHALL equal NOT(next len == DEPTH).
REQ-019 Because only a completed word can fill the queue, status_out SHALL never drop in the middle of a word.
REQ-020 On a dequeue edge with len_out>0, the head word SHALL be registered into data_out and len_out SHALL decrement on that same edge.
REQ-021 On a dequeue edge with len_out=0, data_out and len_out SHALL be unchanged and underflow_out SHALL be 1 for one cycle.
REQ-022 If a push and a pop occur in the same cycle, both SHALL take effect and len_out SHALL be unchanged; a pop from len=1 concurrent with a push SHALL return the old head word.
REQ-023 The read and write pointers SHALL wrap modulo DEPTH, and ordering SHALL be strict FIFO.
REQ-024 data_out SHALL hold its value between pops.

Reset
REQ-025 Reset SHALL force the following values: len_out=0, data_out=0, status_out=0, underflow_out=0, parity_err_out=0, pointers=0, bit counter=0, shift register=0.
REQ-026 Both previous-strobe registers SHALL reset to 1, so that a strobe held high across reset release is not counted.
REQ-027 status_out SHALL rise on the first clock edge after reset deasserts.
REQ-028 Reset asserted mid-word SHALL discard the partial word, and reset asserted mid-operation SHALL empty the queue.

Configuration
REQ-029 With macro DESER_QUEUE_PARITY_EN defined, each word SHALL be followed by one even-parity bit; the bit counter SHALL run from 0 to DATA_WIDTH, and the push SHALL occur on acceptance of the parity bit.
REQ-030 With DESER_QUEUE_PARITY_EN defined and a parity mismatch, the word SHALL be discarded, len_out SHALL be unchanged, parity_err_out SHALL pulse for one cycle, and the bit counter SHALL return to 0.
REQ-031 Without DESER_QUEUE_PARITY_EN, parity_err_out SHALL be tied to 0 and no parity bit SHALL be expected.

Verification
REQ-032 Scenario (defaults): reset, then send 8 bits of 0x99 LSB-first -> len_out=1; then a dequeue edge -> data_out=0x99 and len_out=0.
REQ-033 Scenario: send 8 words 0x01..0x08 -> status_out=0 and len_out=8; further write edges are ignored; 8 pops return 0x01..0x08 in order, and status_out returns to 1.
REQ-034 Scenario: dequeue edge at len_out=0 -> underflow_out is high for exactly 1 cycle and data_out is unchanged.
REQ-035 Scenario: at len_out=3, the last bit of a word and a dequeue edge fall in the same cycle -> len_out stays 3 and data_out equals the oldest word.
REQ-036 Scenario: send 4 bits, assert reset, release, then send 0xA5 -> one word 0xA5 is queued; write_in held high through reset release is not counted.
REQ-037 Scenario (DESER_QUEUE_PARITY_EN): 0x99 with parity bit 0 -> queued; 0x99 with parity bit 1 -> parity_err_out pulses and len_out is unchanged.
